// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller.
// State encoding and vector mapping live here.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam int VEC_NONE = 0;

  function automatic int vec_of(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder.
// Bit 0 wins over every higher index.
module intr_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level capture, fixed priority,
// and a request/ack/eoi handshake towards the core.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int VEC_W = $clog2(NSRC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   irq,
  input  logic [NSRC-1:0]   edge_mode,
  input  logic [NSRC-1:0]   enable,
  input  logic              gmask,
  input  logic              iack,
  input  logic              eoi,
  output logic              ireq,
  output logic [VEC_W-1:0]  ivec,
  output logic [NSRC-1:0]   pending
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [VEC_W-1:0]  ivec_q;
  logic [VEC_W-1:0]  ivec_d;
  logic [NSRC-1:0]   irq_r;
  logic [NSRC-1:0]   pend_q;
  logic [NSRC-1:0]   pend_d;
  logic [NSRC-1:0]   edge_set;
  logic [NSRC-1:0]   ack_clr;
  logic [NSRC-1:0]   elig;
  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic              cur_elig;

  assign edge_set = irq & ~irq_r;
  assign pending  = (edge_mode & pend_q)
                  | (~edge_mode & irq_r);
  assign elig     = pending & enable
                  & {NSRC{~gmask}};

  intr_prio_enc #(
    .N  (NSRC),
    .IW (IW)
  ) u_prio (
    .req   (elig),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Which source the presented vector names, and whether it still qualifies
  always_comb begin
    cur_elig = 1'b0;
    ack_clr  = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (ivec_q == VEC_W'(vec_of(k))) begin
        cur_elig   = elig[k];
        ack_clr[k] = (state_q == REQ) && iack
                   && edge_mode[k];
      end
    end
  end

  // Edge latch: a fresh edge beats a same-cycle ack clear
  always_comb begin
    pend_d = (pend_q & ~ack_clr)
           | (edge_set & edge_mode);
  end

  // Handshake sequencing and vector selection
  always_comb begin
    state_d = state_q;
    ivec_d  = ivec_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = REQ;
          ivec_d  = VEC_W'(vec_of(int'(win_idx)));
        end else begin
          ivec_d  = VEC_W'(VEC_NONE);
        end
      end
      REQ: begin
        if (iack) begin
          state_d = SERV;
        end else if (gmask || !cur_elig) begin
          state_d = IDLE;
          ivec_d  = VEC_W'(VEC_NONE);
        end
      end
      SERV: begin
        if (eoi) begin
          state_d = IDLE;
          ivec_d  = VEC_W'(VEC_NONE);
        end
      end
      default: begin
        state_d = IDLE;
        ivec_d  = VEC_W'(VEC_NONE);
      end
    endcase
  end

  // State, vector, sampled lines and latched edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ivec_q  <= '0;
      irq_r   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ivec_q  <= ivec_d;
      irq_r   <= irq;
      pend_q  <= pend_d;
    end
  end

  assign ireq = (state_q == REQ);
  assign ivec = ivec_q;

endmodule
